// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter (instruction bus m0, data bus m1) in front of one RAM slave.
// Define WB_ARB_TIMEOUT_EN to add an error termination after TIMEOUT granted cycles without s_ack.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_sel,
    input  logic        m0_we,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_sel,
    input  logic        m1_we,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_sel,
    output logic        s_we,
    output logic        s_cyc,
    output logic        s_stb,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic [1:0]  grant
);

    // Encoding doubles as the one-hot grant, so grant comes straight off the state flops.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;     // 1: m1 was granted most recently
    logic   req0, req1;
    logic   to_armed;           // timeout count reached; independent of s_ack
    logic   to_hit;

    assign req0 = m0_cyc & m0_stb;
    assign req1 = m1_cyc & m1_stb;
    assign to_hit = to_armed & ~s_ack;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign to_armed = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && state_d != IDLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign to_armed = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie, the master that did not own the bus last time wins.
                if (req0 && (!req1 || last_q)) begin
                    state_d = G0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = G1;
                    last_d  = 1'b1;
                end
            end
            G0: begin
                if (s_ack || !m0_cyc || to_hit) begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (s_ack || !m1_cyc || to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant    = state_q;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_comb begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_sel   = m0_sel;
        s_we    = m0_we;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        case (state_q)
            G0: begin
                s_cyc  = m0_cyc & ~to_armed;
                s_stb  = m0_stb & ~to_armed;
                m0_ack = s_ack;
                m0_err = to_hit & m0_cyc;
            end
            G1: begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc & ~to_armed;
                s_stb   = m1_stb & ~to_armed;
                m1_ack  = s_ack;
                m1_err  = to_hit & m1_cyc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed timing checks plus a randomized two-master scoreboard run
// against a single-cycle-ack RAM model.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
    logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_we, s_cyc, s_stb, s_ack;
    logic [1:0]  grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc),
        .s_stb(s_stb), .s_rdata(s_rdata), .s_ack(s_ack), .grant(grant)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 4) return 32'h11223344;
        if (i == 8) return 32'h55667788;
        return 32'hA5A50000 ^ (i * 32'h01030507);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // RAM slave: single-cycle registered ack, optionally stubbed never to ack.
    logic [31:0] ram [0:63];
    logic        ack_q;
    logic [31:0] rd_q;
    logic        no_ack;
    logic        spur;
    assign s_ack   = ack_q | spur;
    assign s_rdata = rd_q;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
            ack_q <= 1'b0;
            rd_q  <= 32'h0;
        end else if (s_cyc && s_stb && !ack_q && !no_ack) begin
            ack_q <= 1'b1;
            rd_q  <= ram[s_addr[7:2]];
            if (s_we) ram[s_addr[7:2]] <= merge(ram[s_addr[7:2]], s_wdata, s_sel);
        end else begin
            ack_q <= 1'b0;
        end
    end

    // Reference memory and per-master expected-response queues.
    typedef struct packed {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ref_mem [0:63];
    exp_t        q0[$];
    exp_t        q1[$];
    logic        sb_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc = req; m0_stb = req; m0_we = we; m0_addr = a; m0_wdata = wd; m0_sel = sel;
        end else begin
            m1_cyc = req; m1_stb = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_sel = sel;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        spur = 1'b0;
        no_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
        chk("rst_errs", {m0_err, m1_err}, 2'b00);
        @(posedge clk); #1 reset = 1'b1;
    endtask

    // One isolated transfer with cycle-exact checks: grant at N+1, ack at N+2, idle at N+3.
    task automatic dir_xfer(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] sel, input logic [31:0] exp_rd, input string tag);
        logic [1:0] own;
        own = (m == 0) ? 2'b01 : 2'b10;
        @(posedge clk); #1 set_m(m, 1'b1, we, a, wd, sel);
        @(negedge clk);
        chk({tag, "_grant_n"}, grant, 2'b00);
        chk({tag, "_scyc_n"}, s_cyc, 1'b0);
        @(negedge clk);
        chk({tag, "_grant_n1"}, grant, own);
        chk({tag, "_sstb_n1"}, s_stb, 1'b1);
        chk({tag, "_swe_n1"}, s_we, we);
        chk({tag, "_ssel_n1"}, s_sel, sel);
        chk({tag, "_saddr_n1"}, s_addr, a);
        chk({tag, "_acks_n1"}, {m1_ack, m0_ack}, 2'b00);
        @(negedge clk);
        chk({tag, "_acks_n2"}, {m1_ack, m0_ack}, own);
        if (!we) chk({tag, "_rdata"}, (m == 0) ? m0_rdata : m1_rdata, exp_rd);
        @(posedge clk); #1 set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk({tag, "_grant_n3"}, grant, 2'b00);
        chk({tag, "_acks_n3"}, {m1_ack, m0_ack}, 2'b00);
    endtask

    task automatic rnd_xfer(input int m);
        exp_t        e;
        int          idx, n;
        logic        we, got;
        logic [31:0] wd;
        logic [3:0]  sel;
        idx = (m == 0) ? int'($urandom_range(32, 47)) : int'($urandom_range(48, 63));
        we  = 1'($urandom_range(0, 1));
        wd  = $urandom;
        sel = 4'($urandom_range(1, 15));
        e.we   = we;
        e.data = ref_mem[idx];
        if (we) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
        if (m == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1 set_m(m, 1'b1, we, 32'(idx * 4), wd, sel);
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
            n++;
        end
        chk((m == 0) ? "m0_wait_ack" : "m1_wait_ack", got, 1'b1);
        @(posedge clk); #1 set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // Monitor: each ack pops that master's expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (m0_ack) begin
                    chk("sb_m0_expected", q0.size() > 0, 1'b1);
                    chk("sb_m0_grant", grant, 2'b01);
                    if (q0.size() > 0) begin
                        e = q0.pop_front();
                        if (!e.we) chk("sb_m0_rdata", m0_rdata, e.data);
                    end
                end
                if (m1_ack) begin
                    chk("sb_m1_expected", q1.size() > 0, 1'b1);
                    chk("sb_m1_grant", grant, 2'b10);
                    if (q1.size() > 0) begin
                        e = q1.pop_front();
                        if (!e.we) chk("sb_m1_rdata", m1_rdata, e.data);
                    end
                end
                if (s_cyc && grant == 2'b00) chk("sb_cyc_idle", s_cyc, 1'b0);
                if (m0_err || m1_err) chk("sb_err", {m0_err, m1_err}, 2'b00);
            end
        end
    end

    initial begin
        logic [1:0] exp_g [12];
        int         na0, na1, owner;
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                  2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

        do_reset();

        // Tied first request after reset, then continuous contention for four transfers.
        na0 = 0;
        na1 = 0;
        @(posedge clk); #1;
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("cont_grant", grant, exp_g[c]);
            if (c % 3 == 2) begin
                owner = (c / 3) % 2;
                chk("cont_m0_ack", m0_ack, owner == 0);
                chk("cont_m1_ack", m1_ack, owner == 1);
                chk("cont_rdata", m0_rdata, (owner == 0) ? 32'h11223344 : 32'h55667788);
                na0 += int'(m0_ack);
                na1 += int'(m1_ack);
            end else begin
                chk("cont_no_ack", {m0_ack, m1_ack}, 2'b00);
            end
        end
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("cont_m0_count", na0, 2);
        chk("cont_m1_count", na1, 2);
        @(negedge clk);
        chk("cont_end_grant", grant, 2'b00);

        do_reset();
        dir_xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h11223344, "rd");
        dir_xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011, 32'h0, "wr");
        dir_xfer(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h5566CCDD, "rdback");

        // Spurious ack while idle reaches no master.
        @(posedge clk); #1 spur = 1'b1;
        @(negedge clk);
        chk("spur_acks", {m0_ack, m1_ack}, 2'b00);
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_grant", grant, 2'b00);

        // Abort: m0 drops cyc while granted; pending m1 is served afterwards.
        no_ack = 1'b1;
        @(posedge clk); #1 set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        @(posedge clk); #1 set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        chk("abort_grant", grant, 2'b01);
        chk("abort_scyc_before", s_cyc, 1'b1);
        #1 set_m(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        chk("abort_scyc_after", s_cyc, 1'b0);
        chk("abort_m0_term", {m0_ack, m0_err}, 2'b00);
        @(negedge clk);
        chk("abort_idle", grant, 2'b00);
        chk("abort_m0_term_idle", {m0_ack, m0_err}, 2'b00);
        #1 no_ack = 1'b0;
        @(negedge clk);
        chk("abort_m1_grant", grant, 2'b10);
        @(negedge clk);
        chk("abort_m1_ack", m1_ack, 1'b1);
        chk("abort_m1_rdata", m1_rdata, 32'h5566CCDD);
        @(posedge clk); #1 set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("abort_end_grant", grant, 2'b00);

`ifdef WB_ARB_TIMEOUT_EN
        // Timeout with a slave that never acks: four strobed cycles, error on the fifth.
        no_ack = 1'b1;
        @(posedge clk); #1 set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        for (int g = 1; g <= 4; g++) begin
            @(negedge clk);
            chk("to_grant", grant, 2'b01);
            chk("to_stb", s_stb, 1'b1);
            chk("to_no_term", {m0_ack, m0_err}, 2'b00);
        end
        @(negedge clk);
        chk("to_err", m0_err, 1'b1);
        chk("to_ack", m0_ack, 1'b0);
        chk("to_stb_forced", {s_cyc, s_stb}, 2'b00);
        @(posedge clk); #1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        no_ack = 1'b0;
        @(negedge clk);
        chk("to_idle", grant, 2'b00);
        chk("to_err_once", m0_err, 1'b0);
`endif

        // Asynchronous reset during G1 takes effect without waiting for a clock edge.
        no_ack = 1'b1;
        @(posedge clk); #1 set_m(1, 1'b1, 1'b1, 32'h24, 32'h12345678, 4'hF);
        @(negedge clk);
        @(negedge clk);
        chk("arst_pre_grant", grant, 2'b10);
        #1 reset = 1'b0;
        #1;
        chk("arst_grant", grant, 2'b00);
        chk("arst_scyc", {s_cyc, s_stb}, 2'b00);
        chk("arst_ack", {m1_ack, m1_err}, 2'b00);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        no_ack = 1'b0;
        do_reset();

        // Randomized concurrent traffic from both masters.
        sb_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 40; k++) rnd_xfer(0);
            end
            begin
                for (int k = 0; k < 40; k++) rnd_xfer(1);
            end
        join
        repeat (5) @(posedge clk);
        sb_on = 1'b0;
        chk("sb_q0_drained", q0.size(), 0);
        chk("sb_q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone classic arbiter placed directly upstream of the SoC RAM slave. It merges the core's instruction bus (master 0) and data bus (master 1) onto the single `ram_*` bus. Arbitration is round-robin with a registered grant, and ownership is held until the slave acks or the master aborts.

## Interface
- `TIMEOUT`, default 255: granted cycles without `s_ack` before error termination (only used under `WB_ARB_TIMEOUT_EN`); range 1..65535.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `m0_addr`, `m0_wdata`  in  32 each  master 0 address and write data.
- `m0_sel`  in  4  master 0 byte selects.
- `m0_we`, `m0_cyc`, `m0_stb`  in  1 each  master 0 controls.
- `m0_rdata`  out  32  read data to master 0.
- `m0_ack`, `m0_err`  out  1 each  termination to master 0.
- `m1_*`  same set as `m0_*`  master 1 (data bus).
- `s_addr`, `s_wdata`  out  32 each  to the slave.
- `s_sel`  out  4  to the slave.
- `s_we`, `s_cyc`, `s_stb`  out  1 each  to the slave.
- `s_rdata`  in  32  slave read data.
- `s_ack`  in  1  slave ack.
- `grant`  out  2  one-hot current owner (`01` = m0, `10` = m1, `00` = idle).

## Operation
- State machine states:
  - IDLE: `grant`=00.
  - G0: `grant`=01.
  - G1: `grant`=10.
- Request: `mX_req = mX_cyc & mX_stb`.
- Arbitration in IDLE:
  - Only m0 requests: go to G0.
  - Only m1 requests: go to G1.
  - Both request: grant the master that was not granted most recently (`last` register).
  - Neither requests: stay in IDLE.
- `last` updates on entry to G0 or G1. Its reset value is "m1", so m0 wins the first tie.
- In GX, the slave outputs are combinational copies of master X: addr, wdata, sel, we, cyc, stb.
- In IDLE, the slave outputs carry m0's addr/wdata/sel/we, with `s_cyc`=`s_stb`=0.
- `m0_rdata` = `m1_rdata` = `s_rdata` (broadcast; qualified by ack).
- Acks:
  - `mX_ack = s_ack & (state == GX)`.
  - The non-owner's ack and err are always 0.
- Leaving GX:
  - `s_ack`=1 goes to IDLE next edge. One dead IDLE cycle follows every transfer, which guarantees the slave sees `stb` low after its ack.
  - `mX_cyc`=0 (abort) goes to IDLE next edge, with no ack or err to X. `s_cyc` follows `mX_cyc` low in that same cycle.
- A request from the other master during GX waits. It is arbitrated in the following IDLE cycle.
- Masters must hold their outputs stable while requesting until ack or err (Wishbone classic). The arbiter does not latch them.

## Timing
- Reset (asynchronous, active-low) forces:
  - state IDLE, `last` = m1, timeout counter 0.
  - `grant`=00, `s_cyc`=`s_stb`=0.
  - `m0_ack`=`m1_ack`=0, `m0_err`=`m1_err`=0.
- Reset takes effect immediately, including mid-transfer. The aborted transfer is never acked.
- Latency with the single-cycle-ack RAM:
  - Request seen in IDLE at cycle N.
  - `s_stb`=1 in cycle N+1.
  - `s_ack` and `mX_ack` = 1 in cycle N+2.
  - IDLE in cycle N+3.
  - Worst case: 3 cycles per transfer; 6 cycles for a tied pair.
- `grant` is registered. All other outputs are combinational from the state and the inputs; there is no combinational path from `s_ack` to the slave outputs.
- If `s_ack` arrives in IDLE (spurious), it is ignored: no master ack.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(`TIMEOUT`+1) clears on entry to GX and increments each GX cycle without `s_ack`.
  - In the GX cycle where count == `TIMEOUT` and `s_ack`=0:
    - `mX_err`=1 for exactly that cycle.
    - `s_cyc` and `s_stb` are forced 0.
    - Next state is IDLE.
  - If `s_ack`=1 in that same cycle, ack wins and err stays 0.
- Undefined:
  - No counter is built and `m0_err`/`m1_err` are tied 0.
  - The arbiter waits indefinitely for `s_ack`.

## Test plan
- Single read: reset released, RAM word at 0x10 = 0x11223344, m0 reads 0x10.
  - Required: `grant`=01 one cycle after the request; `m0_ack`=1 for exactly one cycle two cycles after the request, with `m0_rdata`=0x11223344; `m1_ack` stays 0.
- Simultaneous first request: m0 and m1 raise requests on the same cycle right after reset.
  - Required: m0 served first, then m1; `grant` sequence 01, 00, 10, 00.
- Continuous contention: both masters request continuously for 4 transfers.
  - Required: grants alternate m0, m1, m0, m1; each master gets exactly 2 acks.
- Masked write: m1 writes 0xAABBCCDD to 0x20 with sel=0011 while m0 is idle.
  - Required: `s_we`=1 and `s_sel`=0011 only while `grant`=10; a subsequent m0 read of 0x20 returns upper bytes unchanged and low half 0xCCDD.
- Abort: m0 drops `cyc` in its first granted cycle, with the slave stubbed to never ack.
  - Required: IDLE next cycle, `s_cyc`=0, no `m0_ack` or `m0_err`; a pending m1 request is granted after that.
- Timeout: with `WB_ARB_TIMEOUT_EN`, `TIMEOUT`=4, and a slave that never acks, m0 reads.
  - Required: `s_stb` high for 4 granted cycles; `m0_err`=1 on the 5th granted cycle; `m0_ack`=0 throughout; IDLE afterwards.
- Async reset mid-transfer: assert reset during G1.
  - Required: `grant`=00 and `s_cyc`=0 immediately, with no ack.
